// File: rtl/rv_pkg.sv
// Shared constants and types for the integer register-file writeback path.
package rv_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned NREGS = 32;
  localparam int unsigned AW    = $clog2(NREGS);

  typedef logic [AW-1:0] reg_addr_t;

  // Which requester owns the register-file write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE,
    WB_FAST,
    WB_SLOW_BUF,
    WB_SLOW_DIR
  } wb_src_e;

  typedef enum logic {
    SKID_EMPTY,
    SKID_HELD
  } skid_state_e;

endpackage

// File: rtl/wb_skid_buf.sv
// One-entry skid buffer for long-latency results that lose write-port
// arbitration to the fast path. Accepts only when empty; drains as soon as
// the fast path releases the port.
module wb_skid_buf
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid_i,
  output logic            in_ready_o,
  input  logic [AW-1:0]   in_rd_i,
  input  logic [XLEN-1:0] in_data_i,
  input  logic            out_block_i,
  output logic            out_valid_o,
  output logic [AW-1:0]   out_rd_o,
  output logic [XLEN-1:0] out_data_o
);

  skid_state_e     state_q, state_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;

  // State and payload registers; reset discards any held result.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SKID_EMPTY;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

  // Capture a blocked result when empty; release it once the port is free.
  always_comb begin
    state_d     = state_q;
    rd_d        = rd_q;
    data_d      = data_q;
    in_ready_o  = (state_q == SKID_EMPTY);
    out_valid_o = (state_q == SKID_HELD);
    case (state_q)
      SKID_EMPTY: begin
        if (in_valid_i && out_block_i) begin
          rd_d    = in_rd_i;
          data_d  = in_data_i;
          state_d = SKID_HELD;
        end
      end
      SKID_HELD: begin
        if (!out_block_i) state_d = SKID_EMPTY;
      end
    endcase
  end

  assign out_rd_o   = rd_q;
  assign out_data_o = data_q;

endmodule

// File: rtl/reg_writeback_ctrl.sv
// Register-file writer: arbitrates fast-path and long-latency writes, keeps a
// pending-write scoreboard and raises decode hazards.
// Optional macro REG_WB_FWD_EN adds fwd_rs1_o/fwd_rs2_o and lets a slow
// write in flight on we3 stop stalling its readers that cycle.
module reg_writeback_ctrl
  import rv_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            issue_valid_i,
  input  logic [AW-1:0]   issue_rd_i,
  input  logic            fast_valid_i,
  input  logic [AW-1:0]   fast_rd_i,
  input  logic [XLEN-1:0] fast_data_i,
  input  logic            slow_valid_i,
  output logic            slow_ready_o,
  input  logic [AW-1:0]   slow_rd_i,
  input  logic [XLEN-1:0] slow_data_i,
  input  logic [AW-1:0]   q_rs1_i,
  input  logic [AW-1:0]   q_rs2_i,
  input  logic [AW-1:0]   q_rd_i,
  output logic            stall_o,
  output logic            we3,
  output logic [AW-1:0]   a3,
  output logic [XLEN-1:0] wd3
`ifdef REG_WB_FWD_EN
  ,
  output logic            fwd_rs1_o,
  output logic            fwd_rs2_o
`endif
);

  logic [NREGS-1:0] pending_q, pending_d;
  logic [NREGS-1:0] set_mask, clr_mask, visible;
  logic             buf_valid;
  logic [AW-1:0]    buf_rd;
  logic [XLEN-1:0]  buf_data;
  wb_src_e          wb_src;
  logic [AW-1:0]    sel_rd;
  logic [XLEN-1:0]  sel_data;
  logic             slow_wr;

  wb_skid_buf u_skid (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid_i  (slow_valid_i),
    .in_ready_o  (slow_ready_o),
    .in_rd_i     (slow_rd_i),
    .in_data_i   (slow_data_i),
    .out_block_i (fast_valid_i),
    .out_valid_o (buf_valid),
    .out_rd_o    (buf_rd),
    .out_data_o  (buf_data)
  );

  // Write-port arbitration: fast, then buffered slow, then direct slow.
  // Direct slow is only reachable while the buffer is empty (ready=1).
  always_comb begin
    wb_src   = WB_NONE;
    sel_rd   = '0;
    sel_data = '0;
    if (fast_valid_i) begin
      wb_src   = WB_FAST;
      sel_rd   = fast_rd_i;
      sel_data = fast_data_i;
    end else if (buf_valid) begin
      wb_src   = WB_SLOW_BUF;
      sel_rd   = buf_rd;
      sel_data = buf_data;
    end else if (slow_valid_i) begin
      wb_src   = WB_SLOW_DIR;
      sel_rd   = slow_rd_i;
      sel_data = slow_data_i;
    end
  end

  assign we3     = (wb_src != WB_NONE) && (sel_rd != '0);
  assign a3      = we3 ? sel_rd : '0;
  assign wd3     = we3 ? sel_data : '0;
  assign slow_wr = we3 && ((wb_src == WB_SLOW_BUF) || (wb_src == WB_SLOW_DIR));

  // Scoreboard update masks; set is applied after clear so it wins.
  always_comb begin
    set_mask  = '0;
    clr_mask  = '0;
    if (issue_valid_i && (issue_rd_i != '0)) set_mask = NREGS'(1) << issue_rd_i;
    if (slow_wr) clr_mask = NREGS'(1) << sel_rd;
    pending_d = (pending_q & ~clr_mask) | set_mask;
  end

  // Pending-write scoreboard register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_q <= '0;
    else        pending_q <= pending_d;
  end

`ifdef REG_WB_FWD_EN
  assign visible   = pending_q & ~clr_mask;
  assign fwd_rs1_o = we3 && (a3 == q_rs1_i) && (a3 != '0);
  assign fwd_rs2_o = we3 && (a3 == q_rs2_i) && (a3 != '0);
`else
  assign visible   = pending_q;
`endif

  assign stall_o = visible[q_rs1_i] | visible[q_rs2_i] | visible[q_rd_i];

  a_issue_free: assert property (@(posedge clk) disable iff (!rst_n)
    (issue_valid_i && (issue_rd_i != '0)) |-> !pending_q[issue_rd_i]);

  a_slow_pending: assert property (@(posedge clk) disable iff (!rst_n)
    (slow_valid_i && slow_ready_o && (slow_rd_i != '0)) |-> pending_q[slow_rd_i]);

  a_slow_stable: assert property (@(posedge clk) disable iff (!rst_n)
    (slow_valid_i && !slow_ready_o) |=> ($stable(slow_rd_i) && $stable(slow_data_i)));

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Self-checking bench for reg_writeback_ctrl: directed scenarios plus a
// randomized run checked against a queue-based behavioural model.
module tb_reg_writeback_ctrl;
  import rv_pkg::*;

`ifdef REG_WB_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            issue_valid;
  logic [AW-1:0]   issue_rd;
  logic            fast_valid;
  logic [AW-1:0]   fast_rd;
  logic [XLEN-1:0] fast_data;
  logic            slow_valid;
  logic            slow_ready;
  logic [AW-1:0]   slow_rd;
  logic [XLEN-1:0] slow_data;
  logic [AW-1:0]   q_rs1, q_rs2, q_rd;
  logic            stall, we3;
  logic [AW-1:0]   a3;
  logic [XLEN-1:0] wd3;
`ifdef REG_WB_FWD_EN
  logic            fwd_rs1, fwd_rs2;
`endif

  int unsigned total = 0;
  int unsigned bad   = 0;

  always #5 clk = ~clk;

  reg_writeback_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .issue_valid_i(issue_valid),
    .issue_rd_i   (issue_rd),
    .fast_valid_i (fast_valid),
    .fast_rd_i    (fast_rd),
    .fast_data_i  (fast_data),
    .slow_valid_i (slow_valid),
    .slow_ready_o (slow_ready),
    .slow_rd_i    (slow_rd),
    .slow_data_i  (slow_data),
    .q_rs1_i      (q_rs1),
    .q_rs2_i      (q_rs2),
    .q_rd_i       (q_rd),
    .stall_o      (stall),
    .we3          (we3),
    .a3           (a3),
    .wd3          (wd3)
`ifdef REG_WB_FWD_EN
    ,
    .fwd_rs1_o    (fwd_rs1),
    .fwd_rs2_o    (fwd_rs2)
`endif
  );

  task automatic idle();
    issue_valid = 0; issue_rd = '0;
    fast_valid = 0;  fast_rd = '0;  fast_data = '0;
    slow_valid = 0;  slow_rd = '0;  slow_data = '0;
    q_rs1 = '0; q_rs2 = '0; q_rd = '0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    idle();
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    idle();
    rst_n = 1;
    #3 rst_n = 0;
    #1;
    total++; if (we3 !== 1'b0) begin bad++; $display("FAIL reset_we3 got=%b exp=0", we3); end
    total++; if (a3 !== '0) begin bad++; $display("FAIL reset_a3 got=%0d exp=0", a3); end
    total++; if (wd3 !== '0) begin bad++; $display("FAIL reset_wd3 got=%h exp=0", wd3); end
    total++; if (slow_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%b exp=1", slow_ready); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_fast();
    @(negedge clk);
    fast_valid = 1; fast_rd = 5'd5; fast_data = 32'h11; q_rs1 = 5'd5;
    #1;
    total++; if (we3 !== 1'b1) begin bad++; $display("FAIL fast_we3 got=%b exp=1", we3); end
    total++; if (a3 !== 5'd5) begin bad++; $display("FAIL fast_a3 got=%0d exp=5", a3); end
    total++; if (wd3 !== 32'h11) begin bad++; $display("FAIL fast_wd3 got=%h exp=11", wd3); end
    @(negedge clk);
    fast_valid = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL fast_no_pending got=%b exp=0", stall); end
    idle();
  endtask

  task automatic test_slow_hazard();
    @(negedge clk);
    issue_valid = 1; issue_rd = 5'd7;
    @(negedge clk);
    issue_valid = 0; q_rs1 = 5'd7;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL raw_stall got=%b exp=1", stall); end
    @(negedge clk);
    q_rs1 = '0; q_rs2 = 5'd7;
    slow_valid = 1; slow_rd = 5'd7; slow_data = 32'hAB;
    #1;
    total++; if (we3 !== 1'b1) begin bad++; $display("FAIL slow_we3 got=%b exp=1", we3); end
    total++; if (a3 !== 5'd7) begin bad++; $display("FAIL slow_a3 got=%0d exp=7", a3); end
    total++; if (wd3 !== 32'hAB) begin bad++; $display("FAIL slow_wd3 got=%h exp=ab", wd3); end
    total++; if (stall !== !FWD) begin bad++; $display("FAIL write_cycle_stall got=%b exp=%b", stall, !FWD); end
`ifdef REG_WB_FWD_EN
    total++; if (fwd_rs2 !== 1'b1) begin bad++; $display("FAIL fwd_rs2 got=%b exp=1", fwd_rs2); end
    total++; if (fwd_rs1 !== 1'b0) begin bad++; $display("FAIL fwd_rs1 got=%b exp=0", fwd_rs1); end
`endif
    @(negedge clk);
    slow_valid = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL after_write_stall got=%b exp=0", stall); end
    idle();
  endtask

  task automatic test_skid();
    @(negedge clk);
    issue_valid = 1; issue_rd = 5'd3;
    @(negedge clk);
    issue_valid = 0;
    slow_valid = 1; slow_rd = 5'd3; slow_data = 32'hAB;
    fast_valid = 1; fast_rd = 5'd4; fast_data = 32'h44;
    #1;
    total++; if (a3 !== 5'd4 || wd3 !== 32'h44) begin bad++; $display("FAIL skid_fast_wins got=%0d/%h exp=4/44", a3, wd3); end
    total++; if (slow_ready !== 1'b1) begin bad++; $display("FAIL skid_accept got=%b exp=1", slow_ready); end
    @(negedge clk);
    fast_valid = 0; slow_valid = 0; q_rs1 = 5'd3;
    #1;
    total++; if (slow_ready !== 1'b0) begin bad++; $display("FAIL skid_held_ready got=%b exp=0", slow_ready); end
    total++; if (we3 !== 1'b1 || a3 !== 5'd3 || wd3 !== 32'hAB) begin bad++; $display("FAIL skid_drain got=%b/%0d/%h exp=1/3/ab", we3, a3, wd3); end
    total++; if (stall !== !FWD) begin bad++; $display("FAIL skid_drain_stall got=%b exp=%b", stall, !FWD); end
    @(negedge clk);
    #1;
    total++; if (slow_ready !== 1'b1 || we3 !== 1'b0 || stall !== 1'b0) begin bad++; $display("FAIL skid_empty got=%b/%b/%b exp=1/0/0", slow_ready, we3, stall); end
    idle();
  endtask

  task automatic test_zero();
    @(negedge clk);
    fast_valid = 1; fast_rd = '0; fast_data = 32'h55;
    #1;
    total++; if (we3 !== 1'b0) begin bad++; $display("FAIL fast_x0_we3 got=%b exp=0", we3); end
    @(negedge clk);
    fast_valid = 0; slow_valid = 1; slow_rd = '0; slow_data = 32'h66;
    #1;
    total++; if (we3 !== 1'b0 || slow_ready !== 1'b1) begin bad++; $display("FAIL slow_x0 got=we%b/rdy%b exp=we0/rdy1", we3, slow_ready); end
    @(negedge clk);
    slow_valid = 0; issue_valid = 1; issue_rd = '0;
    #1;
    total++; if (slow_ready !== 1'b1) begin bad++; $display("FAIL slow_x0_done got=%b exp=1", slow_ready); end
    @(negedge clk);
    issue_valid = 0;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL issue_x0_stall got=%b exp=0", stall); end
    idle();
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    issue_valid = 1; issue_rd = 5'd9;
    @(negedge clk);
    issue_rd = 5'd10; q_rd = 5'd9;
    #1;
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL waw_stall got=%b exp=1", stall); end
    @(negedge clk);
    issue_valid = 0;
    slow_valid = 1; slow_rd = 5'd10; slow_data = 32'hC0DE;
    fast_valid = 1; fast_rd = 5'd1; fast_data = 32'h1;
    @(negedge clk);
    slow_valid = 0; fast_rd = 5'd2; q_rs1 = 5'd10;
    #1;
    total++; if (slow_ready !== 1'b0) begin bad++; $display("FAIL held_under_fast got=%b exp=0", slow_ready); end
    #1 fast_valid = 0; rst_n = 0;
    #1;
    total++; if (stall !== 1'b0 || slow_ready !== 1'b1 || we3 !== 1'b0) begin bad++; $display("FAIL mid_reset got=st%b/rdy%b/we%b exp=0/1/0", stall, slow_ready, we3); end
    @(negedge clk);
    rst_n = 1;
    #1;
    total++; if (stall !== 1'b0 || we3 !== 1'b0) begin bad++; $display("FAIL post_reset got=st%b/we%b exp=0/0", stall, we3); end
    idle();
  endtask

  typedef struct { logic [AW-1:0] rd; logic [XLEN-1:0] data; } wb_t;

  task automatic test_random();
    bit              pend [NREGS];
    wb_t             bufq [$];
    logic [AW-1:0]   outq [$];
    bit              s_held, exp_rdy, has_wr, slow_sel, exp_we, exp_st, exp_f1, exp_f2, accepted;
    logic [AW-1:0]   w_rd, r;
    logic [XLEN-1:0] w_data;
    int              idx;
    wb_t             ent;
    apply_reset();
    foreach (pend[i]) pend[i] = 0;
    s_held = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      @(negedge clk);
      exp_rdy = (bufq.size() == 0);
      if (!s_held) begin
        if (outq.size() > 0 && $urandom_range(1, 0) == 1) begin
          idx = $urandom_range(outq.size() - 1, 0);
          slow_rd = outq[idx]; outq.delete(idx);
          slow_data = $urandom(); slow_valid = 1; s_held = 1;
        end else if ($urandom_range(9, 0) == 0) begin
          slow_rd = '0; slow_data = $urandom(); slow_valid = 1; s_held = 1;
        end else begin
          slow_valid = 0;
        end
      end
      fast_valid = ($urandom_range(4, 0) < 2);
      fast_rd    = AW'($urandom_range(NREGS - 1, 0));
      fast_data  = $urandom();
      r = AW'($urandom_range(NREGS - 1, 0));
      issue_rd    = r;
      issue_valid = ($urandom_range(2, 0) == 0) && !pend[r];
      q_rs1 = AW'($urandom_range(NREGS - 1, 0));
      q_rs2 = AW'($urandom_range(NREGS - 1, 0));
      q_rd  = AW'($urandom_range(NREGS - 1, 0));
      #1;
      has_wr = 1; slow_sel = 1; w_rd = '0; w_data = '0;
      if (fast_valid) begin slow_sel = 0; w_rd = fast_rd; w_data = fast_data; end
      else if (bufq.size() > 0) begin w_rd = bufq[0].rd; w_data = bufq[0].data; end
      else if (slow_valid) begin w_rd = slow_rd; w_data = slow_data; end
      else begin has_wr = 0; slow_sel = 0; end
      exp_we = has_wr && (w_rd != 0);
      exp_st = 0;
      foreach (pend[i])
        if (pend[i] && (i == int'(q_rs1) || i == int'(q_rs2) || i == int'(q_rd))
            && !(FWD && slow_sel && exp_we && i == int'(w_rd))) exp_st = 1;
      exp_f1 = exp_we && (w_rd == q_rs1);
      exp_f2 = exp_we && (w_rd == q_rs2);
      total++; if (slow_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, slow_ready, exp_rdy); end
      total++; if (we3 !== exp_we) begin bad++; $display("FAIL rnd_we3 cyc=%0d got=%b exp=%b", cyc, we3, exp_we); end
      if (exp_we) begin
        total++; if (a3 !== w_rd || wd3 !== w_data) begin bad++; $display("FAIL rnd_write cyc=%0d got=%0d/%h exp=%0d/%h", cyc, a3, wd3, w_rd, w_data); end
      end
      total++; if (stall !== exp_st) begin bad++; $display("FAIL rnd_stall cyc=%0d got=%b exp=%b", cyc, stall, exp_st); end
`ifdef REG_WB_FWD_EN
      total++; if (fwd_rs1 !== exp_f1 || fwd_rs2 !== exp_f2) begin bad++; $display("FAIL rnd_fwd cyc=%0d got=%b%b exp=%b%b", cyc, fwd_rs1, fwd_rs2, exp_f1, exp_f2); end
`else
      if (exp_f1 || exp_f2) idx = 0;
`endif
      @(posedge clk);
      accepted = slow_valid && exp_rdy;
      if (slow_sel && exp_we) pend[w_rd] = 0;
      if (issue_valid && issue_rd != 0) begin pend[issue_rd] = 1; outq.push_back(issue_rd); end
      if (!fast_valid && bufq.size() > 0) void'(bufq.pop_front());
      if (accepted && fast_valid) begin ent.rd = slow_rd; ent.data = slow_data; bufq.push_back(ent); end
      if (accepted) s_held = 0;
    end
  endtask

  initial begin
    test_reset();
    test_fast();
    test_slow_hazard();
    test_skid();
    test_zero();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
